// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, FSM encoding and MEM/WB bundle for mem_stage
package mem_stage_pkg;

   localparam int DEF_DATA_W      = 16;
   localparam int DEF_REG_AW      = 3;
   localparam int DEF_TIMEOUT_CYC = 15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] read_data;
      logic [DEF_DATA_W-1:0] alu_result;
      logic [DEF_REG_AW-1:0] dest;
      logic                  mem_to_reg;
      logic                  reg_write;
   } mem_wb_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - IDLE/WAIT req/ack handshake with timeout for the memory stage
module mem_bus_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              we_in,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_err
);

   // counter only needs to reach TIMEOUT_CYC-1; the timeout fires on that WAIT cycle
   localparam int              CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // request is simply "in WAIT", so it drops on the same edge that leaves WAIT or resets
   assign busy    = (state_q == ST_WAIT);
   assign mem_req = busy;

   // next-state: ack beats timeout on the same cycle; ack outside WAIT is ignored
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      err     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, counter, bus fields latched at start and held stable through WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mem_err <= err;
         if (start && (state_q == ST_IDLE)) begin
            mem_we    <= we_in;
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage (optional MEM_ALIGN_CHECK_EN: trap odd-address memory ops)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int REG_AW      = DEF_REG_AW,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] write_data_in,
   input  logic [DATA_W-1:0] branch_addr_in,
   input  logic              zero_in,
   input  logic [REG_AW-1:0] dest_reg_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              Branch_in,
   input  logic              MemtoReg_in,
   input  logic              RegWrite_in,
   output logic              stall_out,
   output logic              PCSrc,
   output logic [DATA_W-1:0] branch_addr_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [REG_AW-1:0] dest_reg_out,
   output logic              MemtoReg_out,
   output logic              RegWrite_out,
   output logic              mem_err,
   output logic              align_err
);

   logic    busy, done, err;
   logic    accept, mem_op, misalign, start;
   logic    pend_load;
   mem_wb_t pend_q;
   mem_wb_t wb_q;

   assign stall_out = busy;
   assign accept    = in_valid & ~busy;
   assign mem_op    = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = alu_result_in[0];
`else
   assign misalign = 1'b0;
`endif

   assign start = accept & mem_op & ~misalign;

   assign read_data_out  = wb_q.read_data;
   assign alu_result_out = wb_q.alu_result;
   assign dest_reg_out   = wb_q.dest;
   assign MemtoReg_out   = wb_q.mem_to_reg;
   assign RegWrite_out   = wb_q.reg_write;

   mem_bus_ctrl #(
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_bus (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .we_in     (MemWrite_in),
      .addr_in   (alu_result_in),
      .wdata_in  (write_data_in),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_err   (mem_err)
   );

   // MEM/WB bundle, branch pulse and pending memory-op record; a write always wins over a read
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid        <= 1'b0;
         PCSrc           <= 1'b0;
         branch_addr_out <= '0;
         align_err       <= 1'b0;
         wb_q            <= '0;
         pend_q          <= '0;
         pend_load       <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         PCSrc     <= 1'b0;
         align_err <= 1'b0;
         if (accept) begin
            PCSrc           <= Branch_in & zero_in;
            branch_addr_out <= branch_addr_in;
            if (!mem_op) begin
               wb_q     <= '{read_data: '0, alu_result: alu_result_in, dest: dest_reg_in,
                             mem_to_reg: MemtoReg_in, reg_write: RegWrite_in};
               wb_valid <= 1'b1;
            end else if (misalign) begin
               wb_q      <= '{read_data: '0, alu_result: alu_result_in, dest: dest_reg_in,
                              mem_to_reg: MemtoReg_in, reg_write: 1'b0};
               wb_valid  <= 1'b1;
               align_err <= 1'b1;
            end else begin
               pend_q    <= '{read_data: '0, alu_result: alu_result_in, dest: dest_reg_in,
                              mem_to_reg: MemtoReg_in, reg_write: RegWrite_in & ~MemWrite_in};
               pend_load <= MemRead_in & ~MemWrite_in;
            end
         end
         if (done) begin
            wb_q     <= '{read_data: pend_load ? mem_rdata : '0, alu_result: pend_q.alu_result,
                          dest: pend_q.dest, mem_to_reg: pend_q.mem_to_reg,
                          reg_write: pend_q.reg_write};
            wb_valid <= 1'b1;
         end else if (err) begin
            wb_q     <= '{read_data: '0, alu_result: pend_q.alu_result, dest: pend_q.dest,
                          mem_to_reg: pend_q.mem_to_reg, reg_write: 1'b0};
            wb_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] alu_result_in, write_data_in, branch_addr_in;
   logic        zero_in;
   logic [2:0]  dest_reg_in;
   logic        MemRead_in, MemWrite_in, Branch_in, MemtoReg_in, RegWrite_in;
   logic        stall_out, PCSrc;
   logic [15:0] branch_addr_out;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [15:0] read_data_out, alu_result_out;
   logic [2:0]  dest_reg_out;
   logic        MemtoReg_out, RegWrite_out, mem_err, align_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .alu_result_in(alu_result_in), .write_data_in(write_data_in),
      .branch_addr_in(branch_addr_in), .zero_in(zero_in), .dest_reg_in(dest_reg_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
      .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
      .stall_out(stall_out), .PCSrc(PCSrc), .branch_addr_out(branch_addr_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
      .dest_reg_out(dest_reg_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
      .mem_err(mem_err), .align_err(align_err)
   );

   typedef struct {
      logic [15:0] alu;
      logic [2:0]  dest;
      logic        rw, m2r, br, zero;
      logic [15:0] baddr;
      logic        exp_pcsrc;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [2:0] dest, input logic mr, input logic mw,
                        input logic rw, input logic m2r, input logic br, input logic z,
                        input logic [15:0] baddr);
      in_valid = v; alu_result_in = alu; write_data_in = wd; dest_reg_in = dest;
      MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemtoReg_in = m2r;
      Branch_in = br; zero_in = z; branch_addr_in = baddr;
   endtask

   task automatic idle_in();
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      int req_cnt, stall_cnt, unstable;

      vecs[0] = '{alu: 16'h1234, dest: 3'd5, rw: 1'b1, m2r: 1'b0, br: 1'b0, zero: 1'b0,
                  baddr: 16'h0000, exp_pcsrc: 1'b0};
      vecs[1] = '{alu: 16'h0000, dest: 3'd0, rw: 1'b0, m2r: 1'b0, br: 1'b1, zero: 1'b1,
                  baddr: 16'h0100, exp_pcsrc: 1'b1};
      vecs[2] = '{alu: 16'hFFFF, dest: 3'd7, rw: 1'b1, m2r: 1'b0, br: 1'b1, zero: 1'b0,
                  baddr: 16'h0200, exp_pcsrc: 1'b0};
      vecs[3] = '{alu: 16'h0001, dest: 3'd1, rw: 1'b1, m2r: 1'b1, br: 1'b0, zero: 1'b1,
                  baddr: 16'h0300, exp_pcsrc: 1'b0};

      rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
      idle_in();
      repeat (2) @(negedge clk);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_pcsrc", PCSrc, 0);
      chk("rst_alu_out", alu_result_out, 0);
      chk("rst_mem_err", mem_err, 0);
      rst = 1'b0;

      // single-cycle ALU / branch vectors
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vecs[i].alu, 16'h7777, vecs[i].dest, 1'b0, 1'b0, vecs[i].rw,
               vecs[i].m2r, vecs[i].br, vecs[i].zero, vecs[i].baddr);
         @(negedge clk);
         chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
         chk($sformatf("v%0d_alu_out", i), alu_result_out, vecs[i].alu);
         chk($sformatf("v%0d_dest", i), dest_reg_out, vecs[i].dest);
         chk($sformatf("v%0d_regwrite", i), RegWrite_out, vecs[i].rw);
         chk($sformatf("v%0d_memtoreg", i), MemtoReg_out, vecs[i].m2r);
         chk($sformatf("v%0d_pcsrc", i), PCSrc, vecs[i].exp_pcsrc);
         chk($sformatf("v%0d_baddr", i), branch_addr_out, vecs[i].baddr);
         chk($sformatf("v%0d_rdata", i), read_data_out, 0);
         chk($sformatf("v%0d_stall", i), stall_out, 0);
         chk($sformatf("v%0d_req", i), mem_req, 0);
         idle_in();
         @(negedge clk);
         chk($sformatf("v%0d_wb_drop", i), wb_valid, 0);
         chk($sformatf("v%0d_pcsrc_drop", i), PCSrc, 0);
         chk($sformatf("v%0d_alu_hold", i), alu_result_out, vecs[i].alu);
      end

      // load at 0x0040, ack on third WAIT cycle
      drive(1'b1, 16'h0040, 16'h9999, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      req_cnt = 0; stall_cnt = 0; unstable = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         idle_in();
         if (!mem_req) break;
         req_cnt++;
         if (stall_out) stall_cnt++;
         if (mem_addr !== 16'h0040 || mem_we !== 1'b0) unstable++;
         if (req_cnt == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      end
      mem_ack = 1'b0; mem_rdata = 16'h0;
      chk("ld_req_cycles", req_cnt, 3);
      chk("ld_stall_cycles", stall_cnt, 3);
      chk("ld_bus_stable", unstable, 0);
      chk("ld_wb_valid", wb_valid, 1);
      chk("ld_rdata", read_data_out, 16'hBEEF);
      chk("ld_regwrite", RegWrite_out, 1);
      chk("ld_dest", dest_reg_out, 3);
      chk("ld_alu_out", alu_result_out, 16'h0040);
      chk("ld_stall_after", stall_out, 0);

      // store 0xA5A5 to 0x0010, zero-wait ack, then back-to-back ALU op
      drive(1'b1, 16'h0010, 16'hA5A5, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      idle_in();
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 16'h0010);
      chk("st_wdata", mem_wdata, 16'hA5A5);
      chk("st_wb_early", wb_valid, 0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("st_wb_valid", wb_valid, 1);
      chk("st_regwrite", RegWrite_out, 0);
      chk("st_rdata", read_data_out, 0);
      chk("st_req_drop", mem_req, 0);
      drive(1'b1, 16'h5555, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      idle_in();
      chk("b2b_wb_valid", wb_valid, 1);
      chk("b2b_alu_out", alu_result_out, 16'h5555);

      // MemRead and MemWrite both set: write wins, no register write
      drive(1'b1, 16'h0020, 16'h1111, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      idle_in();
      chk("rw_we", mem_we, 1);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rw_wb_valid", wb_valid, 1);
      chk("rw_regwrite", RegWrite_out, 0);
      chk("rw_rdata", read_data_out, 0);

      // timeout: no ack at all
      drive(1'b1, 16'h0080, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      req_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         idle_in();
         if (!mem_req) break;
         req_cnt++;
      end
      chk("to_req_cycles", req_cnt, 15);
      chk("to_mem_err", mem_err, 1);
      chk("to_wb_valid", wb_valid, 1);
      chk("to_regwrite", RegWrite_out, 0);
      @(negedge clk);
      chk("to_err_pulse", mem_err, 0);

      // ack arriving on the timeout cycle completes normally
      drive(1'b1, 16'h0082, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      req_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         idle_in();
         if (!mem_req) break;
         req_cnt++;
         if (req_cnt == 15) begin mem_ack = 1'b1; mem_rdata = 16'h4321; end
      end
      mem_ack = 1'b0;
      chk("tack_req_cycles", req_cnt, 15);
      chk("tack_mem_err", mem_err, 0);
      chk("tack_rdata", read_data_out, 16'h4321);
      chk("tack_regwrite", RegWrite_out, 1);

      // reset while in WAIT, then a late ack
      drive(1'b1, 16'h00C0, 16'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      idle_in();
      chk("rw_wait_req", mem_req, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_req", mem_req, 0);
      chk("rstw_stall", stall_out, 0);
      chk("rstw_addr", mem_addr, 0);
      chk("rstw_alu_out", alu_result_out, 0);
      chk("rstw_wb_valid", wb_valid, 0);
      mem_ack = 1'b1; mem_rdata = 16'hFACE;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_wb", wb_valid, 0);
      chk("late_ack_rdata", read_data_out, 0);
      chk("late_ack_req", mem_req, 0);

      // odd-address load
      drive(1'b1, 16'h0041, 16'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      idle_in();
`ifdef MEM_ALIGN_CHECK_EN
      chk("al_align_err", align_err, 1);
      chk("al_req", mem_req, 0);
      chk("al_stall", stall_out, 0);
      chk("al_wb_valid", wb_valid, 1);
      chk("al_regwrite", RegWrite_out, 0);
      @(negedge clk);
      chk("al_err_pulse", align_err, 0);
`else
      chk("al_align_err", align_err, 0);
      chk("al_req", mem_req, 1);
      chk("al_addr", mem_addr, 16'h0041);
      mem_ack = 1'b1; mem_rdata = 16'h0A0A;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("al_wb_valid", wb_valid, 1);
      chk("al_rdata", read_data_out, 16'h0A0A);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit pipelined RISC core; sits directly downstream of the execute stage.
- Consumes the ALU result, store data, branch target, zero flag and destination register from execute.
- Performs data-memory loads and stores over a req/ack bus, resolves branches, and presents a registered MEM/WB bundle to write-back.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- DATA_W, 16, datapath and address width
- REG_AW, 3, register-file index width
- TIMEOUT_CYC, 15, max cycles waiting for mem_ack before abort (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute bundle valid this cycle
- alu_result_in  in  DATA_W  ALU result / memory byte address
- write_data_in  in  DATA_W  store data (register read data 2)
- branch_addr_in  in  DATA_W  branch target from execute
- zero_in  in  1  ALU zero flag
- dest_reg_in  in  REG_AW  selected rd/rt
- MemRead_in, MemWrite_in, Branch_in, MemtoReg_in, RegWrite_in  in  1 each  control bits
- stall_out  out  1  upstream must hold; in_valid ignored while high
- PCSrc  out  1  take-branch pulse
- branch_addr_out  out  DATA_W  registered branch target
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  bus address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  transaction complete
- wb_valid  out  1  MEM/WB bundle valid (1-cycle pulse)
- read_data_out, alu_result_out  out  DATA_W each  MEM/WB data
- dest_reg_out  out  REG_AW  MEM/WB destination
- MemtoReg_out, RegWrite_out  out  1 each  MEM/WB control
- mem_err  out  1  timeout pulse
- align_err  out  1  misalignment pulse (see Optional Feature)

Behaviour:
- Reset: every output 0; state IDLE; timeout counter 0.
  - Reset mid-transaction: mem_req drops at that edge; a late mem_ack is ignored.
- FSM states IDLE and WAIT. stall_out = (state == WAIT), combinational.
- IDLE, in_valid=1, no memory op (MemRead=MemWrite=0):
  - Bundle registered; wb_valid=1 next cycle (latency 1).
  - read_data_out = 0.
  - PCSrc = Branch_in & zero_in, registered with branch_addr_out as a 1-cycle pulse.
- IDLE, in_valid=1, memory op:
  - Latch addr, wdata, dest and control; mem_req=1 next cycle; enter WAIT.
  - mem_we = MemWrite_in. If MemRead and MemWrite are both set, the write wins and RegWrite_out is forced 0.
  - PCSrc is pulsed as for a non-memory op.
- WAIT: mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack.
  - mem_ack=1: capture mem_rdata (loads only; stores give 0), drop mem_req, wb_valid=1 next cycle, return to IDLE. The next instruction can be accepted the cycle after the ack.
  - Zero-wait ack (ack in the first WAIT cycle) is legal; total latency 2.
- Timeout: counter increments each WAIT cycle without ack. On reaching TIMEOUT_CYC:
  - mem_err pulses; mem_req drops.
  - wb_valid pulses with RegWrite_out=0; return to IDLE.
  - An ack on the timeout cycle wins: normal completion, no error.
- in_valid=0 in IDLE: wb_valid=0, PCSrc=0, other registered outputs hold.
- Address and data are pass-through, no arithmetic; addresses are byte addresses of 16-bit words.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: a memory op with alu_result_in[0]=1 issues no bus request and never enters WAIT.
  - align_err pulses.
  - wb_valid pulses next cycle with RegWrite_out=0.
- MEM_ALIGN_CHECK_EN undefined: the address goes to the bus unchanged and align_err is tied 0. The port exists in both builds.

Decomposition:
- Package mem_stage_pkg:
  - DATA_W, REG_AW and TIMEOUT_CYC defaults
  - state encoding (IDLE, WAIT)
  - MEM/WB bundle typedef: data, alu result, dest, MemtoReg, RegWrite
- One sub-module, mem_bus_ctrl: owns the IDLE/WAIT FSM, the req/ack handshake and the timeout counter; exposes start, done and err to mem_stage.

Test Plan:
- ALU op: alu_result_in=0x1234, dest=5, RegWrite=1 -> next cycle wb_valid=1, alu_result_out=0x1234, dest_reg_out=5, stall_out never high.
- Load at 0x0040, ack after 3 WAIT cycles with rdata=0xBEEF -> mem_req high for 3 cycles, stall_out high for 3 cycles, read_data_out=0xBEEF, wb_valid one cycle after the ack.
- Store 0xA5A5 to 0x0010, ack in the first WAIT cycle -> mem_we=1, mem_wdata=0xA5A5 stable, wb_valid with RegWrite_out=0, total latency 2.
- Branch=1, zero=1, branch_addr_in=0x0100 -> PCSrc pulse, branch_addr_out=0x0100; with zero=0 -> PCSrc stays 0.
- Load, no ack for TIMEOUT_CYC=15 cycles -> mem_err pulse at cycle 15, mem_req drops, RegWrite_out=0. Separately, rst asserted in WAIT -> all outputs 0 next edge, and a later ack is ignored.
- MEM_ALIGN_CHECK_EN build: load at 0x0041 -> align_err pulse, mem_req stays 0, wb_valid with RegWrite_out=0.
